dfd_dbus_trace_capture: RTL and testbench
=========================================

DFD_DBUS_TRACE_CAPTURE -- requirements
Module: dfd_dbus_trace_capture

Interface
REQ-001 SHALL have parameter DEBUG_BUS_WIDTH, default 64, width of the captured debug bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries in the capture FIFO, power of two, minimum 2.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port debug_bus, input, DEBUG_BUS_WIDTH, the mux-selected debug bus.
REQ-007 SHALL have port cfg_enable, input, 1, capture enable.
REQ-008 SHALL have port cfg_mask, input, DEBUG_BUS_WIDTH, change-compare mask where 1 = compared.
REQ-009 SHALL have port start_trig, input, 1, start capture.
REQ-010 SHALL have port stop_trig, input, 1, stop capture.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1, which form the drain handshake.
REQ-012 SHALL have port out_data, output, DEBUG_BUS_WIDTH, the head entry sample.
REQ-013 SHALL have port out_tdelta, output, 16, cycles since the previous capture event.
REQ-014 SHALL have port out_ovf, output, 1, meaning one or more events were dropped before this entry.
REQ-015 SHALL have port state, output, 2, current FSM state; port drop_cnt, output, 8, dropped events; and port fifo_level, output, clog2(FIFO_DEPTH)+1, occupancy.

Function
REQ-016 FSM states SHALL be IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
REQ-017 IDLE SHALL move to ARMED when cfg_enable=1.
REQ-018 ARMED SHALL move to CAPTURE on start_trig=1.
REQ-019 CAPTURE SHALL move to STOPPED on stop_trig=1.
REQ-020 Any state SHALL move to IDLE when cfg_enable=0, and this SHALL take priority over all other transitions.
REQ-021 start_trig and stop_trig asserted together in ARMED SHALL go to CAPTURE only; stop_trig SHALL be ignored outside CAPTURE.
REQ-022 A capture event SHALL occur on the ARMED->CAPTURE transition cycle, unconditionally.
REQ-023 A capture event SHALL also occur in any CAPTURE cycle (stop cycle included) where ((debug_bus ^ last_val) & mask) != 0.
REQ-024 last_val SHALL load debug_bus on every capture event, whether the event is accepted or dropped.
REQ-025 A 16-bit delta counter SHALL increment every CAPTURE cycle and saturate at 0xFFFF.
REQ-026 On each capture event, the entry SHALL carry the current delta counter value (0 on the start event), and the counter SHALL be cleared to 1 for the next cycle.
REQ-027 A write SHALL be accepted when the FIFO is not full, or when the FIFO is full and a pop (out_valid & out_ready) occurs in the same cycle; otherwise the event SHALL be dropped.
REQ-028 A dropped event SHALL increment drop_cnt, saturating at 255, and SHALL set pending_ovf.
REQ-029 The next accepted entry SHALL carry out_ovf=1 and SHALL clear pending_ovf.
REQ-030 The IDLE->ARMED transition SHALL clear drop_cnt, pending_ovf and last_val.
REQ-031 The FIFO contents SHALL survive all state changes and SHALL keep draining in every state.
REQ-032 out_valid SHALL equal FIFO-not-empty; an entry SHALL become visible on out_* the cycle after its capture event (1-cycle latency).
REQ-033 out_* SHALL be held stable while out_valid=1 and out_ready=0.
REQ-034 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and fifo_level SHALL be exact through simultaneous push and pop.

Reset
REQ-035 Reset SHALL force: state=IDLE; FIFO empty; out_valid=0; out_data, out_tdelta and out_ovf = 0; drop_cnt=0; fifo_level=0; delta counter, last_val and pending_ovf = 0.
REQ-036 Reset asserted mid-capture SHALL discard all FIFO contents.

Configuration
REQ-037 With DFD_DBUS_CAPTURE_MASK_EN defined, the compare SHALL use cfg_mask.
REQ-038 With DFD_DBUS_CAPTURE_MASK_EN undefined, mask SHALL be all-ones, cfg_mask SHALL be ignored, and no mask logic SHALL be synthesized.

Structure
REQ-039 The state enum, the entry struct {ovf, tdelta[15:0], data} and the 16-bit delta width constant SHALL live in dfd_dst_pkg.
REQ-040 The FIFO SHALL be a sub-module named dfd_trace_sync_fifo, with push/pop/full/empty/level ports and show-ahead read.

Verification
REQ-041 SHALL cover: enable, start with debug_bus=0x1111 -> entry {data 0x1111, tdelta 0, ovf 0} with out_valid at start+1.
REQ-042 SHALL cover: in CAPTURE, bus changes 0x1111->0x2222 after 5 idle cycles -> entry {0x2222, tdelta 6, ovf 0}.
REQ-043 SHALL cover: with mask 0xFF00 (macro defined), a bus change 0x2222->0x22FF -> no entry; macro undefined -> an entry.
REQ-044 SHALL cover: out_ready=0, 10 changes with FIFO_DEPTH=8 -> 8 entries, drop_cnt=2, the next accepted entry has ovf=1, and the entry after it has ovf=0.
REQ-045 SHALL cover: FIFO full, and a change coincides with a pop -> the change is accepted, drop_cnt is unchanged, fifo_level stays 8.
REQ-046 SHALL cover: stop_trig together with a bus change -> that change is captured, state=STOPPED, and later changes are ignored; cfg_enable=0 -> IDLE while the FIFO still drains.

Source files
------------

// File: rtl/dfd_dst_pkg.sv
// Shared types for the debug-bus trace capture block: FSM state encoding,
// the FIFO entry layout and the timestamp-delta width.
package dfd_dst_pkg;

    localparam int DST_DELTA_W = 16;
    localparam int DST_BUS_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STOPPED = 2'd3
    } dst_state_e;

    // The data field is sized for the default bus width; other widths are
    // zero-extended or truncated at the entry boundary.
    typedef struct packed {
        logic                   ovf;
        logic [DST_DELTA_W-1:0] tdelta;
        logic [DST_BUS_W-1:0]   data;
    } dst_entry_t;

endpackage

// File: rtl/dfd_trace_sync_fifo.sv
// Single-clock show-ahead FIFO with exact occupancy; head word reads as zero
// when empty so the drain outputs are clean after reset.
module dfd_trace_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dfd_dbus_trace_capture.sv
// Debug-bus trace capture: arms, starts on a trigger, then logs change events
// with cycle deltas into a FIFO. Define DFD_DBUS_CAPTURE_MASK_EN to honour cfg_mask.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | disabled; FIFO still drains
// ST_ARMED   | enabled, waiting for start_trig
// ST_CAPTURE | logging start event and masked bus changes
// ST_STOPPED | capture ended by stop_trig; waits for cfg_enable=0
module dfd_dbus_trace_capture
    import dfd_dst_pkg::*;
#(
    parameter int DEBUG_BUS_WIDTH = 64,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DEBUG_BUS_WIDTH-1:0]   debug_bus,
    input  logic                         cfg_enable,
    input  logic [DEBUG_BUS_WIDTH-1:0]   cfg_mask,
    input  logic                         start_trig,
    input  logic                         stop_trig,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEBUG_BUS_WIDTH-1:0]   out_data,
    output logic [15:0]                  out_tdelta,
    output logic                         out_ovf,
    output logic [1:0]                   state,
    output logic [7:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    dst_state_e                 state_q, state_d;
    logic [DEBUG_BUS_WIDTH-1:0] last_val;
    logic [DEBUG_BUS_WIDTH-1:0] mask;
    logic [DST_DELTA_W-1:0]     delta_q;
    logic                       pending_ovf;
    logic [7:0]                 drop_q;
    logic                       arm, start_evt, chg_evt, cap_evt;
    logic                       push, pop, drop, full, empty;
    dst_entry_t                 wr_entry, rd_entry;

`ifdef DFD_DBUS_CAPTURE_MASK_EN
    assign mask = cfg_mask;
`else
    logic unused_cfg_mask;
    assign unused_cfg_mask = ^cfg_mask;
    assign mask            = '1;
`endif

    always_comb begin
        state_d = state_q;
        if (!cfg_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARMED;
                ST_ARMED:   if (start_trig) state_d = ST_CAPTURE;
                ST_CAPTURE: if (stop_trig)  state_d = ST_STOPPED;
                default:    state_d = state_q;
            endcase
        end
    end

    assign arm       = (state_q == ST_IDLE) && cfg_enable;
    assign start_evt = (state_q == ST_ARMED) && cfg_enable && start_trig;
    assign chg_evt   = (state_q == ST_CAPTURE) && cfg_enable
                       && (|((debug_bus ^ last_val) & mask));
    assign cap_evt   = start_evt | chg_evt;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = cap_evt && (!full || pop);
    assign drop      = cap_evt && !push;

    assign wr_entry = '{ovf:    pending_ovf,
                        tdelta: start_evt ? '0 : delta_q,
                        data:   DST_BUS_W'(debug_bus)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_val    <= '0;
            delta_q     <= '0;
            pending_ovf <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q <= state_d;
            if (arm) begin
                last_val    <= '0;
                pending_ovf <= 1'b0;
                drop_q      <= '0;
            end else begin
                if (cap_evt) last_val <= debug_bus;
                if (drop) begin
                    pending_ovf <= 1'b1;
                    if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                end else if (push) begin
                    pending_ovf <= 1'b0;
                end
            end
            if (cap_evt)
                delta_q <= DST_DELTA_W'(1);
            else if (state_q == ST_CAPTURE && delta_q != '1)
                delta_q <= delta_q + DST_DELTA_W'(1);
        end
    end

    dfd_trace_sync_fifo #(
        .WIDTH ($bits(dst_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign out_valid  = !empty;
    assign out_data   = DEBUG_BUS_WIDTH'(rd_entry.data);
    assign out_tdelta = rd_entry.tdelta;
    assign out_ovf    = rd_entry.ovf;
    assign state      = state_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dfd_dbus_trace_capture.sv
// Directed bench for dfd_dbus_trace_capture; expectations follow the build's
// DFD_DBUS_CAPTURE_MASK_EN setting.
module tb_dfd_dbus_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] debug_bus;
    logic        cfg_enable;
    logic [63:0] cfg_mask;
    logic        start_trig;
    logic        stop_trig;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] out_tdelta;
    logic        out_ovf;
    logic [1:0]  state;
    logic [7:0]  drop_cnt;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DFD_DBUS_CAPTURE_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    dfd_dbus_trace_capture #(
        .DEBUG_BUS_WIDTH (64),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .debug_bus  (debug_bus),
        .cfg_enable (cfg_enable),
        .cfg_mask   (cfg_mask),
        .start_trig (start_trig),
        .stop_trig  (stop_trig),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tdelta (out_tdelta),
        .out_ovf    (out_ovf),
        .state      (state),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_d   [8];
    logic        exp_ovf [8];
    logic [63:0] exp_lvl;

    initial begin
        reset      = 1'b1;
        debug_bus  = 64'h0;
        cfg_enable = 1'b0;
        cfg_mask   = 64'hFF00;
        start_trig = 1'b0;
        stop_trig  = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk_eq("rst_state",  64'(state), 64'd0);
        chk_eq("rst_valid",  64'(out_valid), 64'd0);
        chk_eq("rst_data",   out_data, 64'd0);
        chk_eq("rst_tdelta", 64'(out_tdelta), 64'd0);
        chk_eq("rst_ovf",    64'(out_ovf), 64'd0);
        chk_eq("rst_drop",   64'(drop_cnt), 64'd0);
        chk_eq("rst_level",  64'(fifo_level), 64'd0);
        reset = 1'b0;
        tick();

        // enable -> ARMED, start -> CAPTURE with start entry next cycle
        cfg_enable = 1'b1;
        debug_bus  = 64'h1111;
        tick();
        chk_eq("arm_state", 64'(state), 64'd1);
        chk_eq("arm_valid", 64'(out_valid), 64'd0);
        start_trig = 1'b1;
        tick();
        start_trig = 1'b0;
        chk_eq("start_state",  64'(state), 64'd2);
        chk_eq("start_valid",  64'(out_valid), 64'd1);
        chk_eq("start_data",   out_data, 64'h1111);
        chk_eq("start_tdelta", 64'(out_tdelta), 64'd0);
        chk_eq("start_ovf",    64'(out_ovf), 64'd0);

        // drain, then change on the sixth capture cycle
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq("pop_level", 64'(fifo_level), 64'd0);
        repeat (4) tick();
        debug_bus = 64'h2222;
        tick();
        chk_eq("chg_data",   out_data, 64'h2222);
        chk_eq("chg_tdelta", 64'(out_tdelta), 64'd6);
        chk_eq("chg_ovf",    64'(out_ovf), 64'd0);
        chk_eq("chg_level",  64'(fifo_level), 64'd1);

        // low-byte change is masked only when the mask feature is built in
        debug_bus = 64'h22FF;
        tick();
        exp_lvl = MASK_ON ? 64'd1 : 64'd2;
        chk_eq("mask_level", 64'(fifo_level), exp_lvl);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk_eq("mask_drain", 64'(fifo_level), 64'd0);

        // ten changes with no drain: 8 stored, 2 dropped
        for (int i = 0; i < 10; i++) begin
            debug_bus = 64'h1000 + 64'(i) * 64'h100;
            tick();
        end
        chk_eq("ovf_level", 64'(fifo_level), 64'd8);
        chk_eq("ovf_drop",  64'(drop_cnt), 64'd2);
        chk_eq("ovf_head",  out_data, 64'h1000);
        chk_eq("ovf_hovf",  64'(out_ovf), 64'd0);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq("ovf_pop_level", 64'(fifo_level), 64'd7);
        debug_bus = 64'h3000;
        tick();
        chk_eq("ovf_acc_level", 64'(fifo_level), 64'd8);
        chk_eq("ovf_acc_drop",  64'(drop_cnt), 64'd2);

        // full FIFO, change coincides with pop
        out_ready = 1'b1;
        debug_bus = 64'h3100;
        tick();
        out_ready = 1'b0;
        chk_eq("fullpop_level", 64'(fifo_level), 64'd8);
        chk_eq("fullpop_drop",  64'(drop_cnt), 64'd2);

        exp_d[0] = 64'h1200; exp_d[1] = 64'h1300; exp_d[2] = 64'h1400; exp_d[3] = 64'h1500;
        exp_d[4] = 64'h1600; exp_d[5] = 64'h1700; exp_d[6] = 64'h3000; exp_d[7] = 64'h3100;
        for (int i = 0; i < 8; i++) exp_ovf[i] = (i == 6);
        for (int i = 0; i < 8; i++) begin
            chk_eq($sformatf("drain_data%0d", i), out_data, exp_d[i]);
            chk_eq($sformatf("drain_ovf%0d", i), 64'(out_ovf), 64'(exp_ovf[i]));
            if (i == 6) chk_eq("drain_tdelta6", 64'(out_tdelta), 64'd2);
            if (i == 7) chk_eq("drain_tdelta7", 64'(out_tdelta), 64'd1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk_eq("drain_level", 64'(fifo_level), 64'd0);

        // stop together with a change
        stop_trig = 1'b1;
        debug_bus = 64'h4000;
        tick();
        stop_trig = 1'b0;
        chk_eq("stop_state", 64'(state), 64'd3);
        chk_eq("stop_level", 64'(fifo_level), 64'd1);
        chk_eq("stop_data",  out_data, 64'h4000);
        debug_bus = 64'h5000;
        tick();
        chk_eq("stopped_level", 64'(fifo_level), 64'd1);
        cfg_enable = 1'b0;
        tick();
        chk_eq("dis_state", 64'(state), 64'd0);
        chk_eq("dis_valid", 64'(out_valid), 64'd1);
        chk_eq("dis_data",  out_data, 64'h4000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq("dis_drained", 64'(out_valid), 64'd0);

        // re-arm clears drop count; reset mid-capture flushes FIFO
        cfg_enable = 1'b1;
        tick();
        chk_eq("rearm_state", 64'(state), 64'd1);
        chk_eq("rearm_drop",  64'(drop_cnt), 64'd0);
        start_trig = 1'b1;
        debug_bus  = 64'h6000;
        tick();
        start_trig = 1'b0;
        debug_bus  = 64'h7000;
        tick();
        chk_eq("pre_rst_level", 64'(fifo_level), 64'd2);
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_level", 64'(fifo_level), 64'd0);
        chk_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        chk_eq("mid_rst_state", 64'(state), 64'd0);
        chk_eq("mid_rst_data",  out_data, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
